// File: rtl/mem_host_pkg.sv
// Shared types and defaults for the scratch-RAM host initiator.
// Holds the FSM state encoding and the idle levels of the RAM control pins.
package mem_host_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 4;

  localparam logic CE_N_IDLE = 1'b1;
  localparam logic LR_N_IDLE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/mem_host_checker.sv
// Read-data checker: compares each returned beat against base+i, registered with rsp_valid.
// Sticky err_flag plus an error counter that saturates at 255.
module mem_host_checker
  import mem_host_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] base,
  input  logic              sample,
  input  logic [DATA_W-1:0] rdata,
  output logic              err_flag,
  output logic [7:0]        err_count
);

  logic [DATA_W-1:0] exp_q, exp_d;
  logic              err_flag_q, err_flag_d;
  logic [7:0]        err_count_q, err_count_d;

  always_comb begin
    exp_d       = exp_q;
    err_flag_d  = err_flag_q;
    err_count_d = err_count_q;
    if (start) begin
      exp_d = base;
    end else if (sample) begin
      exp_d = exp_q + DATA_W'(1);
    end
    if (sample && (rdata != exp_q)) begin
      err_flag_d = 1'b1;
      if (err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q       <= '0;
      err_flag_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      exp_q       <= exp_d;
      err_flag_q  <= err_flag_d;
      err_count_q <= err_count_d;
    end
  end

  assign err_flag  = err_flag_q;
  assign err_count = err_count_q;

endmodule

// File: rtl/mem_host_initiator.sv
// Burst initiator for the scratch-RAM pins: pins follow accept by one cycle, read data returns 3 edges after accept.
// cmd_ready only in IDLE (held-off commands wait, never dropped); read checking under MEM_HOST_VERIFY_EN.
module mem_host_initiator
  import mem_host_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ce_n,
  output logic              mem_lr_n,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_flag,
  output logic [7:0]        err_count
);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_ce_n_q, mem_ce_n_d;
  logic              mem_lr_n_q, mem_lr_n_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_ce_n_d  = CE_N_IDLE;
    mem_lr_n_d  = LR_N_IDLE;
    // A read issued this cycle is captured by the RAM at the coming edge and sampled one edge later.
    rd_pend_d   = ~mem_ce_n_q;
    rsp_valid_d = rd_pend_q;
    rsp_data_d  = rd_pend_q ? mem_rdata : rsp_data_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          len_d       = cmd_len;
          cnt_d       = '0;
          mem_addr_d  = cmd_addr;
          mem_wdata_d = cmd_data;
          if (cmd_write) begin
            state_d    = WRITE;
            mem_lr_n_d = 1'b0;
          end else begin
            state_d    = READ;
            mem_ce_n_d = 1'b0;
          end
        end
      end
      WRITE: begin
        if (cnt_q == len_q) begin
          state_d = IDLE;
        end else begin
          cnt_d       = cnt_q + LEN_W'(1);
          mem_addr_d  = mem_addr_q + ADDR_W'(1);
          mem_wdata_d = mem_wdata_q + DATA_W'(1);
          mem_lr_n_d  = 1'b0;
        end
      end
      READ: begin
        if (cnt_q == len_q) begin
          state_d = DRAIN;
        end else begin
          cnt_d      = cnt_q + LEN_W'(1);
          mem_addr_d = mem_addr_q + ADDR_W'(1);
          mem_ce_n_d = 1'b0;
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_ce_n_q  <= CE_N_IDLE;
      mem_lr_n_q  <= LR_N_IDLE;
      rd_pend_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_ce_n_q  <= mem_ce_n_d;
      mem_lr_n_q  <= mem_lr_n_d;
      rd_pend_q   <= rd_pend_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_ce_n  = mem_ce_n_q;
  assign mem_lr_n  = mem_lr_n_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

`ifdef MEM_HOST_VERIFY_EN
  mem_host_checker #(
    .DATA_W (DATA_W)
  ) u_checker (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (cmd_valid & cmd_ready & ~cmd_write),
    .base      (cmd_data),
    .sample    (rd_pend_q),
    .rdata     (mem_rdata),
    .err_flag  (err_flag),
    .err_count (err_count)
  );
`else
  assign err_flag  = 1'b0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_mem_host_initiator.sv
// Directed bench for mem_host_initiator with a behavioural 16x8 scratch RAM attached to the pins.
`timescale 1ns/1ps
module tb_mem_host_initiator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [3:0] cmd_addr = '0;
  logic [3:0] cmd_len = '0;
  logic [7:0] cmd_data = '0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic [3:0] mem_addr;
  logic       mem_ce_n;
  logic       mem_lr_n;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       err_flag;
  logic [7:0] err_count;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int acc_cnt = 0;

`ifdef MEM_HOST_VERIFY_EN
  localparam logic       EXP_FLAG = 1'b1;
  localparam logic [7:0] EXP_CNT  = 8'd1;
`else
  localparam logic       EXP_FLAG = 1'b0;
  localparam logic [7:0] EXP_CNT  = 8'd0;
`endif

  always #5 clk = ~clk;

  mem_host_initiator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_ce_n  (mem_ce_n),
    .mem_lr_n  (mem_lr_n),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .err_flag  (err_flag),
    .err_count (err_count)
  );

  // Scratch RAM: writes whenever lr_n is low, registered read when ce_n is low.
  logic [7:0] ram [16];
  always @(posedge clk) begin
    if (mem_lr_n == 1'b0) begin
      ram[mem_addr] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (mem_ce_n == 1'b0) mem_rdata <= ram[mem_addr];
    if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
  end

  // Returns at the negedge of the cycle after the accept edge (beat 0 on the pins).
  task automatic send(input logic wr, input logic [3:0] a, input logic [3:0] l, input logic [7:0] d);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_data = d;
    n = 0;
    while (!cmd_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: cmd_ready got 0 required 1");
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    int w0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    w0 = wr_cnt;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++; if (mem_lr_n !== 1'b1) begin n_err++; $display("FAIL rst_lr_n: got %b required 1", mem_lr_n); end
      n_cmp++; if (mem_ce_n !== 1'b1) begin n_err++; $display("FAIL rst_ce_n: got %b required 1", mem_ce_n); end
      n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_cmd_ready: got %b required 1", cmd_ready); end
      n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b required 0", busy); end
    end
    n_cmp++; if (wr_cnt != w0) begin n_err++; $display("FAIL rst_no_write: got %0d writes required 0", wr_cnt - w0); end
    n_cmp++; if (mem_addr !== 4'h0) begin n_err++; $display("FAIL rst_addr: got %h required 0", mem_addr); end
    n_cmp++; if (rsp_data !== 8'h00) begin n_err++; $display("FAIL rst_rsp_data: got %h required 00", rsp_data); end
    n_cmp++; if (err_flag !== 1'b0 || err_count !== 8'h00) begin n_err++; $display("FAIL rst_err: got %b/%0d required 0/0", err_flag, err_count); end
  endtask

  task automatic test_single();
    send(1'b1, 4'd3, 4'd0, 8'hA5);
    n_cmp++; if (mem_lr_n !== 1'b0 || mem_ce_n !== 1'b1) begin n_err++; $display("FAIL single_wr_pins: got lr_n=%b ce_n=%b required 0/1", mem_lr_n, mem_ce_n); end
    n_cmp++; if (mem_addr !== 4'd3 || mem_wdata !== 8'hA5) begin n_err++; $display("FAIL single_wr_addr_data: got %h/%h required 3/a5", mem_addr, mem_wdata); end
    n_cmp++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL single_wr_busy: got ready=%b busy=%b required 0/1", cmd_ready, busy); end
    send(1'b0, 4'd3, 4'd0, 8'hA5);
    n_cmp++; if (mem_ce_n !== 1'b0 || mem_lr_n !== 1'b1 || mem_addr !== 4'd3) begin n_err++; $display("FAIL single_rd_pins: got ce_n=%b lr_n=%b addr=%h required 0/1/3", mem_ce_n, mem_lr_n, mem_addr); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_rd_early1: got %b required 0", rsp_valid); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0 || mem_ce_n !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL single_rd_drain: got rv=%b ce_n=%b busy=%b required 0/1/1", rsp_valid, mem_ce_n, busy); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 8'hA5) begin n_err++; $display("FAIL single_rd_rsp: got rv=%b data=%h required 1/a5", rsp_valid, rsp_data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_rd_idle: got busy=%b required 0", busy); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_rd_pulse: got %b required 0", rsp_valid); end
  endtask

  task automatic test_burst_wrap();
    logic [3:0] ea;
    logic [7:0] ed;
    send(1'b1, 4'd14, 4'd3, 8'h10);
    for (int k = 0; k < 4; k++) begin
      ea = 4'(14 + k);
      ed = 8'(16 + k);
      n_cmp++; if (mem_lr_n !== 1'b0 || mem_addr !== ea || mem_wdata !== ed) begin n_err++; $display("FAIL burst_wr_beat%0d: got lr_n=%b addr=%h data=%h required 0/%h/%h", k, mem_lr_n, mem_addr, mem_wdata, ea, ed); end
      @(negedge clk);
    end
    n_cmp++; if (mem_lr_n !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL burst_wr_end: got lr_n=%b busy=%b required 1/0", mem_lr_n, busy); end
    send(1'b0, 4'd14, 4'd3, 8'h10);
    for (int c = 1; c <= 7; c++) begin
      ea = 4'(14 + c - 1);
      ed = 8'(16 + c - 3);
      if (c <= 4) begin
        n_cmp++; if (mem_ce_n !== 1'b0 || mem_addr !== ea) begin n_err++; $display("FAIL burst_rd_pins_c%0d: got ce_n=%b addr=%h required 0/%h", c, mem_ce_n, mem_addr, ea); end
      end else begin
        n_cmp++; if (mem_ce_n !== 1'b1) begin n_err++; $display("FAIL burst_rd_ce_c%0d: got %b required 1", c, mem_ce_n); end
      end
      if (c >= 3 && c <= 6) begin
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== ed) begin n_err++; $display("FAIL burst_rd_rsp_c%0d: got rv=%b data=%h required 1/%h", c, rsp_valid, rsp_data, ed); end
      end else begin
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL burst_rd_norsp_c%0d: got %b required 0", c, rsp_valid); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int a0;
    send(1'b0, 4'd0, 4'd7, 8'h00);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'd2; cmd_len = 4'd0;
    a0 = acc_cnt;
    n = 0;
    while (!cmd_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    n_cmp++; if (n != 9) begin n_err++; $display("FAIL b2b_ready_low: got %0d cycles required 9", n); end
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL b2b_last_rsp_overlap: got %b required 1", rsp_valid); end
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++; if (acc_cnt - a0 != 1) begin n_err++; $display("FAIL b2b_accept_once: got %0d accepts required 1", acc_cnt - a0); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got busy=%b required 0", busy); end
  endtask

  task automatic test_reset_mid_burst();
    int w0;
    logic [7:0] ex [6];
    ex[0] = 8'h40; ex[1] = 8'h41; ex[2] = 8'h82; ex[3] = 8'h83; ex[4] = 8'h84; ex[5] = 8'h85;
    send(1'b1, 4'd8, 4'd5, 8'h80);
    repeat (6) @(negedge clk);
    w0 = wr_cnt;
    send(1'b1, 4'd8, 4'd5, 8'h40);
    repeat (2) @(negedge clk);
    n_cmp++; if (mem_addr !== 4'd10 || mem_lr_n !== 1'b0) begin n_err++; $display("FAIL rmid_beat2: got addr=%h lr_n=%b required a/0", mem_addr, mem_lr_n); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (mem_lr_n !== 1'b1 || mem_ce_n !== 1'b1) begin n_err++; $display("FAIL rmid_pins_idle: got lr_n=%b ce_n=%b required 1/1", mem_lr_n, mem_ce_n); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b required 0", busy); end
    repeat (2) @(negedge clk);
    n_cmp++; if (wr_cnt - w0 != 2) begin n_err++; $display("FAIL rmid_writes: got %0d required 2", wr_cnt - w0); end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rmid_no_rsp_c%0d: got %b required 0", c, rsp_valid); end
    end
    send(1'b0, 4'd8, 4'd5, 8'h40);
    for (int c = 1; c <= 8; c++) begin
      if (c >= 3) begin
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== ex[c-3]) begin n_err++; $display("FAIL rmid_readback_%0d: got rv=%b data=%h required 1/%h", c - 3, rsp_valid, rsp_data, ex[c-3]); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_verify();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b1, 4'd0, 4'd15, 8'h00);
    repeat (16) @(negedge clk);
    send(1'b0, 4'd0, 4'd3, 8'h00);
    repeat (8) @(negedge clk);
    n_cmp++; if (err_flag !== 1'b0 || err_count !== 8'd0) begin n_err++; $display("FAIL verify_clean: got %b/%0d required 0/0", err_flag, err_count); end
    send(1'b1, 4'd5, 4'd0, 8'hFF);
    send(1'b0, 4'd0, 4'd15, 8'h00);
    repeat (20) @(negedge clk);
    n_cmp++; if (err_flag !== EXP_FLAG) begin n_err++; $display("FAIL verify_flag: got %b required %b", err_flag, EXP_FLAG); end
    n_cmp++; if (err_count !== EXP_CNT) begin n_err++; $display("FAIL verify_count: got %0d required %0d", err_count, EXP_CNT); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_wrap();
    test_back_to_back();
    test_reset_mid_burst();
    test_verify();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_host_initiator.md
Name: mem_host_initiator

Overview:
- Initiator side of the 16-byte DFF scratch-RAM pin interface: addr[3:0], ce_n, lr_n, write data and registered read data.
- Accepts single or burst read/write commands over a valid/ready handshake.
- Sequences the RAM pins cycle-accurately and returns read data as a response stream.
- Sits between on-chip control logic (or a test harness) and the RAM macro.

Parameters:
ADDR_W, 4, RAM address width; addresses wrap modulo 2^ADDR_W
DATA_W, 8, data width
LEN_W, 4, burst length field width; beats = cmd_len+1

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE; accept = cmd_valid & cmd_ready at rising edge
cmd_write  in  1  1=write burst, 0=read burst
cmd_addr  in  ADDR_W  start address
cmd_len  in  LEN_W  beats minus one
cmd_data  in  DATA_W  write base value (beat i writes cmd_data+i, mod 2^DATA_W); expected base in verify mode
rsp_valid  out  1  one-cycle pulse per read beat, no backpressure
rsp_data  out  DATA_W  read beat data
busy  out  1  state != IDLE
mem_addr  out  ADDR_W  to RAM address pins
mem_ce_n  out  1  RAM chip enable, active-low (read qualifier)
mem_lr_n  out  1  RAM load/read_n: 0=write, 1=read/idle
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM registered read data, valid cycle after read issue
err_flag  out  1  sticky verify mismatch (feature only)
err_count  out  8  saturating mismatch count (feature only)

Behaviour:
- All outputs registered except cmd_ready and busy (decoded from state).
- Reset values: mem_ce_n=1, mem_lr_n=1, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_data=0, err_flag=0, err_count=0, state=IDLE.
- RAM writes whenever lr_n=0, regardless of ce_n. mem_lr_n must therefore be 1 in every non-WRITE cycle.
- FSM states:
  - IDLE: pins at idle values.
    - Accept with cmd_write=1 -> WRITE.
    - Accept with cmd_write=0 -> READ.
    - Latch addr, len and data; beat counter = 0.
  - WRITE: per cycle, drive mem_lr_n=0, mem_ce_n=1, mem_addr=base+i, mem_wdata=data+i.
    - After beat len: -> IDLE, lr_n back to 1.
    - N beats occupy exactly N cycles.
  - READ: per cycle, drive mem_ce_n=0, mem_lr_n=1, mem_addr=base+i.
    - After beat len: -> DRAIN.
  - DRAIN: one cycle, ce_n=1; captures the last mem_rdata; -> IDLE.
- Read latency:
  - Accept edge E0; pins driven cycle after E0; RAM captures at E1; mem_rdata sampled at E2.
  - rsp_valid high in the cycle after E2 (3 edges after accept).
  - Subsequent beats follow back-to-back, one per cycle.
- Address wrap: 4'hF+1 -> 4'h0 within a burst. Data increment wraps mod 2^DATA_W.
- cmd_ready=0 in WRITE/READ/DRAIN; commands offered then are held off, not dropped.
- Min command spacing: write N+1 cycles, read N+2 cycles.
- Last read rsp_valid may coincide with a new accept.
- Async reset mid-burst: pins return to idle values immediately, no further RAM writes, pending responses discarded, no rsp_valid after release.

Optional Feature:
- Macro: MEM_HOST_VERIFY_EN.
- With macro defined:
  - Each read beat is compared to cmd_data+i.
  - A mismatch sets err_flag (sticky until reset) and increments err_count, saturating at 255.
  - The compare is registered alongside rsp_valid.
- Without macro defined: err_flag and err_count are tied to 0 and no compare logic is built.
- Ports are present in both builds.

Decomposition:
- Package mem_host_pkg holds:
  - state enum {IDLE, WRITE, READ, DRAIN}
  - ADDR_W/DATA_W/LEN_W defaults
  - idle pin constants (CE_N_IDLE=1, LR_N_IDLE=1)
- Sub-module mem_host_checker holds the verify compare/counter. It is instantiated only under MEM_HOST_VERIFY_EN.

Test Plan:
- Reset then idle 5 cycles -> mem_lr_n=1, mem_ce_n=1, cmd_ready=1, no RAM write.
- Write addr=3, len=0, data=8'hA5; then read addr=3, len=0 -> rsp_valid 3 cycles after read accept, rsp_data=8'hA5.
- Write addr=14, len=3, data=8'h10; then read addr=14, len=3 -> addresses 14,15,0,1 and rsp 10,11,12,13 on consecutive cycles.
- Hold cmd_valid during a len=7 read -> cmd_ready low 9 cycles, second command accepted exactly once after DRAIN.
- Assert rst_n=0 at beat 2 of a len=5 write -> mem_lr_n=1 same cycle, addresses after beat 2 unchanged on readback, no rsp_valid.
- Verify build: fill addr 0..15 with base 0, corrupt addr 5 to 8'hFF, read len=15 base 0 -> err_flag=1, err_count=1.
